// File: rtl/rf_wb_arbiter_pkg.sv
// ISA/core shared types plus small helpers for the writeback arbiter.
package rv32i;
  localparam int xlen      = 32;
  localparam int reg_cnt   = 32;
  localparam int reg_num_w = $clog2(reg_cnt);
endpackage

package core;
  typedef struct packed {
    logic                       en;
    logic [rv32i::reg_num_w-1:0] rd_num;
    logic [rv32i::xlen-1:0]     rd_value;
  } rf_write_req_t;

  localparam int rd_num_w   = rv32i::reg_num_w;
  localparam int wb_req_cnt = 4;
  typedef logic [$clog2(wb_req_cnt)-1:0] wb_req_idx_t;
endpackage

package rf_wb_arbiter_pkg;
  // Index width that stays >= 1 even for degenerate counts.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int wrap_add(input int a, input int b, input int n);
    return (a + b) % n;
  endfunction
endpackage

// File: rtl/rf_wb_arbiter_rr_grant_scan.sv
// Combinational round-robin scan: squash/x0 consumes, port-limited grants,
// and same-rd filtering against earlier grants in the same pass.
module rr_grant_scan
  import rf_wb_arbiter_pkg::*;
#(
  parameter int req_cnt        = 4,
  parameter int write_port_cnt = 1,
  parameter int idx_w          = 2,
  parameter int rd_w           = 5
) (
  input  logic                                  en,
  input  logic [idx_w-1:0]                      rr_ptr,
  input  logic [req_cnt-1:0]                    vld,
  input  logic [req_cnt-1:0][rd_w-1:0]          rd,
  input  logic [req_cnt-1:0]                    squash,
  output logic [req_cnt-1:0]                    grant,
  output logic [req_cnt-1:0]                    consume,
  output logic [write_port_cnt-1:0]             port_vld,
  output logic [write_port_cnt-1:0][idx_w-1:0]  port_idx,
  output logic [idx_w-1:0]                      last_idx
);

  int                                 n_grant;
  logic [idx_w-1:0]                   idx;
  logic                               conflict;
  logic [write_port_cnt-1:0][rd_w-1:0] granted_rd;

  always_comb begin
    grant      = '0;
    consume    = '0;
    port_vld   = '0;
    port_idx   = '0;
    last_idx   = rr_ptr;
    granted_rd = '0;
    n_grant    = 0;
    idx        = '0;
    conflict   = 1'b0;
    for (int s = 0; s < req_cnt; s++) begin
      idx      = idx_w'(wrap_add(int'(rr_ptr), s, req_cnt));
      conflict = 1'b0;
      for (int k = 0; k < write_port_cnt; k++)
        if (k < n_grant && granted_rd[k] == rd[idx]) conflict = 1'b1;
      if (en && vld[idx]) begin
        // Squash and x0 are consumed without a port, even when ports are full.
        if (squash[idx] || rd[idx] == '0) begin
          consume[idx] = 1'b1;
        end else if (n_grant < write_port_cnt && !conflict) begin
          grant[idx]   = 1'b1;
          consume[idx] = 1'b1;
          for (int k = 0; k < write_port_cnt; k++)
            if (k == n_grant) begin
              port_vld[k]   = 1'b1;
              port_idx[k]   = idx;
              granted_rd[k] = rd[idx];
            end
          n_grant  = n_grant + 1;
          last_idx = idx;
        end
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback-to-regfile arbiter: round-robin grants onto registered write
// ports, with a pending-write mask decoded from the registered ports.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int req_cnt        = 4,
  parameter int write_port_cnt = 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       en,
  input  core::rf_write_req_t [req_cnt-1:0]          wb_req,
  input  logic [req_cnt-1:0]                         squash,
  output logic [req_cnt-1:0]                         wb_ready,
  output core::rf_write_req_t [write_port_cnt-1:0]   write_req,
  output logic [rv32i::reg_cnt-1:0]                  pend_mask
);

  localparam int idx_w = idx_width(req_cnt);
  localparam int rd_w  = core::rd_num_w;

  logic [idx_w-1:0]                     rr_ptr;
  logic [req_cnt-1:0]                   vld;
  logic [req_cnt-1:0][rd_w-1:0]         rd;
  logic [req_cnt-1:0]                   grant;
  logic [req_cnt-1:0]                   consume;
  logic [write_port_cnt-1:0]            port_vld;
  logic [write_port_cnt-1:0][idx_w-1:0] port_idx;
  logic [idx_w-1:0]                     last_idx;
  core::rf_write_req_t [write_port_cnt-1:0] nxt_req;

  always_comb begin
    for (int i = 0; i < req_cnt; i++) begin
      vld[i] = wb_req[i].en;
      rd[i]  = wb_req[i].rd_num;
    end
  end

  rr_grant_scan #(
    .req_cnt       (req_cnt),
    .write_port_cnt(write_port_cnt),
    .idx_w         (idx_w),
    .rd_w          (rd_w)
  ) u_scan (
    .en      (en & rst),
    .rr_ptr  (rr_ptr),
    .vld     (vld),
    .rd      (rd),
    .squash  (squash),
    .grant   (grant),
    .consume (consume),
    .port_vld(port_vld),
    .port_idx(port_idx),
    .last_idx(last_idx)
  );

  assign wb_ready = consume & {req_cnt{rst}};

  always_comb begin
    nxt_req = '0;
    for (int k = 0; k < write_port_cnt; k++)
      if (port_vld[k]) begin
        nxt_req[k].en       = 1'b1;
        nxt_req[k].rd_num   = wb_req[port_idx[k]].rd_num;
        nxt_req[k].rd_value = wb_req[port_idx[k]].rd_value;
      end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr    <= '0;
      write_req <= '0;
    end else begin
      write_req <= nxt_req;
      if (|grant) rr_ptr <= idx_w'(wrap_add(int'(last_idx), 1, req_cnt));
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int k = 0; k < write_port_cnt; k++)
      if (write_req[k].en) pend_mask[write_req[k].rd_num] = 1'b1;
    pend_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: 1-port instance plus a 2-port instance
// for the same-rd conflict case.
module tb_rf_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic en2 = 1'b0;
  core::rf_write_req_t [3:0] req1, req2;
  logic [3:0]  sq1, sq2, rdy1, rdy2;
  core::rf_write_req_t [0:0] wr1;
  core::rf_write_req_t [1:0] wr2;
  logic [31:0] pm1, pm2;
  int checks = 0;
  int errors = 0;
  int cnt [4];

  always #5 clk = ~clk;

  rf_wb_arbiter #(.req_cnt(4), .write_port_cnt(1)) dut (
    .clk(clk), .rst(rst), .en(en), .wb_req(req1), .squash(sq1),
    .wb_ready(rdy1), .write_req(wr1), .pend_mask(pm1));

  rf_wb_arbiter #(.req_cnt(4), .write_port_cnt(2)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .wb_req(req2), .squash(sq2),
    .wb_ready(rdy2), .write_req(wr2), .pend_mask(pm2));

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic core::rf_write_req_t mk(input logic e, input logic [4:0] r, input logic [31:0] v);
    core::rf_write_req_t q;
    q.en = e; q.rd_num = r; q.rd_value = v;
    return q;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    req1 = '0; req2 = '0; sq1 = '0; sq2 = '0;
    #3;
    chk("rst_wr", 64'(wr1[0]), 64'd0);
    chk("rst_pm", 64'(pm1), 64'd0);
    chk("rst_rdy", 64'(rdy1), 64'd0);
    chk("rst_ptr", 64'(dut.rr_ptr), 64'd0);
    tick(); tick();
    rst = 1'b1;
    en  = 1'b1;

    // single request on requester 2
    req1[2] = mk(1'b1, 5'd5, 32'hDEADBEEF);
    #1 chk("single_rdy", 64'(rdy1), 64'h4);
    tick();
    req1[2] = '0;
    chk("single_wr", 64'(wr1[0]), 64'(mk(1'b1, 5'd5, 32'hDEADBEEF)));
    chk("single_pm", 64'(pm1), 64'h20);
    chk("single_ptr", 64'(dut.rr_ptr), 64'd3);
    tick();
    chk("idle_wr_en", 64'(wr1[0].en), 64'd0);

    // round-robin from rr_ptr 0
    rst = 1'b0; #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req1[i] = mk(1'b1, 5'(i + 1), 32'(32'h100 + i));
      cnt[i] = 0;
    end
    for (int c = 0; c < 5; c++) begin
      #1 chk("rr_rdy", 64'(rdy1), 64'(4'b0001 << (c % 4)));
      if (c < 4) for (int i = 0; i < 4; i++) cnt[i] += int'(rdy1[i]);
      tick();
      chk("rr_wr", 64'(wr1[0]), 64'(mk(1'b1, 5'((c % 4) + 1), 32'(32'h100 + (c % 4)))));
    end
    for (int i = 0; i < 4; i++) chk("rr_once", 64'(cnt[i]), 64'd1);
    req1 = '0;

    // same rd on 2-port instance
    en2 = 1'b1;
    req2[0] = mk(1'b1, 5'd7, 32'h11);
    req2[1] = mk(1'b1, 5'd7, 32'h22);
    #1 chk("conf_rdy_t", 64'(rdy2), 64'h1);
    tick();
    req2[0] = '0;
    chk("conf_wr0_t", 64'(wr2[0]), 64'(mk(1'b1, 5'd7, 32'h11)));
    chk("conf_wr1_t", 64'(wr2[1].en), 64'd0);
    #1 chk("conf_rdy_t1", 64'(rdy2), 64'h2);
    tick();
    req2[1] = '0;
    chk("conf_wr0_t1", 64'(wr2[0]), 64'(mk(1'b1, 5'd7, 32'h22)));
    chk("conf_wr1_t1", 64'(wr2[1].en), 64'd0);

    // squash and x0 (rr_ptr is 1 after the round-robin run)
    req1[1] = mk(1'b1, 5'd9, 32'h99);
    sq1[1]  = 1'b1;
    req1[2] = mk(1'b1, 5'd0, 32'h77);
    #1 chk("sq_rdy", 64'(rdy1), 64'h6);
    tick();
    req1 = '0; sq1 = '0;
    chk("sq_wr_en", 64'(wr1[0].en), 64'd0);
    chk("sq_pm", 64'(pm1), 64'd0);
    chk("sq_ptr", 64'(dut.rr_ptr), 64'd1);

    // stall
    en = 1'b0;
    req1[3] = mk(1'b1, 5'd12, 32'hCAFE);
    for (int c = 0; c < 3; c++) begin
      #1 chk("stall_rdy", 64'(rdy1), 64'd0);
      tick();
      chk("stall_wr_en", 64'(wr1[0].en), 64'd0);
    end
    en = 1'b1;
    #1 chk("unstall_rdy", 64'(rdy1), 64'h8);
    tick();
    req1[3] = '0;
    chk("unstall_wr", 64'(wr1[0]), 64'(mk(1'b1, 5'd12, 32'hCAFE)));
    chk("unstall_pm", 64'(pm1), 64'h1000);

    // async reset while a write is on the port
    req1[0] = mk(1'b1, 5'd3, 32'h33);
    req1[2] = mk(1'b1, 5'd4, 32'h44);
    #2 rst = 1'b0;
    #1;
    chk("arst_wr", 64'(wr1[0]), 64'd0);
    chk("arst_pm", 64'(pm1), 64'd0);
    chk("arst_rdy", 64'(rdy1), 64'd0);
    tick();
    chk("arst_rdy_hold", 64'(rdy1), 64'd0);
    rst = 1'b1;
    #1 chk("post_rst_rdy", 64'(rdy1), 64'h1);
    tick();
    req1 = '0;
    chk("post_rst_wr", 64'(wr1[0]), 64'(mk(1'b1, 5'd3, 32'h33)));
    chk("post_rst_ptr", 64'(dut.rr_ptr), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
